clk_wiz: RTL and testbench

CLK_WIZ -- requirements
Module: clk_wiz

---
 rtl/clk_wiz.sv | 114 +++++++++++
 tb/tb_clk_wiz.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clk_wiz.sv
// clk_wiz: lock detector and output clock generator for a differential input clock.
//
// Ports
//   clk_in1_p : positive leg of the differential input clock; the block's only clock
//   clk_in1_n : negative leg; sampled on every rising clk_in1_p edge
//               (0 = valid edge, 1 = fault edge)
//   reset     : synchronous, active-high
//   clk_out1  : generated clock; low while not locked
//   locked    : high once LOCK_CYCLES consecutive valid edges have been seen
//
// Parameters
//   DIV         : output divide ratio, 1 or an even number 2..16
//   LOCK_CYCLES : number of valid edges needed to lock, 1..1023
module clk_wiz #(
  parameter int DIV         = 1,
  parameter int LOCK_CYCLES = 64
) (
  input  logic clk_in1_p,
  input  logic clk_in1_n,
  input  logic reset,
  output logic clk_out1,
  output logic locked
);

  // The lock counter is at least 10 bits wide and grows only if LOCK_CYCLES needs more bits.
  localparam int CW = (LOCK_CYCLES > 1023) ? $clog2(LOCK_CYCLES + 1) : 10;
  localparam logic [CW-1:0] LC = CW'(LOCK_CYCLES);

  logic clk_i;
  assign clk_i = clk_in1_p;

  // A sampled high on the negative leg means the differential pair is broken.
  logic fault;
  assign fault = clk_in1_n;

  // Declaration initialisers make the outputs low before the first clock edge.
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic          locked_q = 1'b0;
  logic          locked_d;

  always_comb begin
    cnt_d    = cnt_q;
    locked_d = locked_q;
    if (fault) begin
      cnt_d    = '0;
      locked_d = 1'b0;
    end else if (!locked_q && cnt_q != LC) begin
      // Lock on the same edge that the counter reaches LOCK_CYCLES.
      cnt_d = cnt_q + CW'(1);
      if (cnt_d == LC) locked_d = 1'b1;
    end
  end

  // Reset is tested first, so it wins over a fault on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

  generate
    if (DIV == 1) begin : g_div1
      // The enable changes only while clk_i is low, so gating cannot chop a high phase.
      logic gen_q = 1'b0;
      always_ff @(negedge clk_i) gen_q <= locked_q;
      assign clk_out1 = clk_i & gen_q;
    end else begin : g_divn
      localparam int HALF = DIV / 2;
      localparam int DW   = $clog2(HALF) + 1;
      localparam logic [DW-1:0] TERM = DW'(HALF - 1);

      logic [DW-1:0] dcnt_q = '0;
      logic [DW-1:0] dcnt_d;
      logic          tog_q = 1'b0;
      logic          tog_d;

      // A fault clears the output on the same edge that drops locked. This keeps
      // clk_out1 from staying high through the fault edge.
      always_comb begin
        dcnt_d = dcnt_q;
        tog_d  = tog_q;
        if (fault || !locked_q) begin
          dcnt_d = '0;
          tog_d  = 1'b0;
        end else if (dcnt_q == TERM) begin
          dcnt_d = '0;
          tog_d  = ~tog_q;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      always_ff @(posedge clk_i) begin
        if (reset) begin
          dcnt_q <= '0;
          tog_q  <= 1'b0;
        end else begin
          dcnt_q <= dcnt_d;
          tog_q  <= tog_d;
        end
      end

      assign clk_out1 = tog_q;
    end
  endgenerate

endmodule

// File: tb/tb_clk_wiz.sv
// Directed bench for clk_wiz. Four instances share one stimulus:
//   u0 DIV=1 LOCK_CYCLES=64, u1 DIV=4 LOCK_CYCLES=8,
//   u2 DIV=2 LOCK_CYCLES=8,  u3 DIV=1 LOCK_CYCLES=1.
// Bit i of lk/co belongs to instance ui.
// The clock loop moves clk_n 1 time unit ahead of each rising clk_p, so the sampled
// value is stable at the edge. fault_req forces that value high for one edge.
module tb_clk_wiz;

  logic clk_p, clk_n, rst, fault_req;
  logic [3:0] lk, co;
  int n_chk = 0;
  int n_fail = 0;

  clk_wiz #(.DIV(1), .LOCK_CYCLES(64)) u0 (.clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst),
                                          .clk_out1(co[0]), .locked(lk[0]));
  clk_wiz #(.DIV(4), .LOCK_CYCLES(8))  u1 (.clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst),
                                          .clk_out1(co[1]), .locked(lk[1]));
  clk_wiz #(.DIV(2), .LOCK_CYCLES(8))  u2 (.clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst),
                                          .clk_out1(co[2]), .locked(lk[2]));
  clk_wiz #(.DIV(1), .LOCK_CYCLES(1))  u3 (.clk_in1_p(clk_p), .clk_in1_n(clk_n), .reset(rst),
                                          .clk_out1(co[3]), .locked(lk[3]));

  initial begin
    clk_p = 1'b0;
    clk_n = 1'b1;
    forever begin
      #4 clk_n = fault_req;
      #1 clk_p = 1'b1;
      #4 clk_n = 1'b1;
      #1 clk_p = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_p);
    #1;
  endtask

  // Settle 1 time unit after the next falling edge.
  task automatic half();
    @(negedge clk_p);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    fault_req = 1'b0;
    #1;
    chk("init_lk", lk, 4'b0000);
    chk("init_co", co, 4'b0000);

    tick(3);
    chk("rst_lk", lk, 4'b0000);
    chk("rst_co", co, 4'b0000);
    @(negedge clk_p) rst = 1'b0;

    // Valid edges after release are numbered e1, e2, ...
    tick(1);  // e1
    chk("e1_lk", lk, 4'b1000);
    chk("e1_co3", co[3], 1'b0);
    half();
    chk("e1n_co3", co[3], 1'b0);
    tick(1);  // e2
    chk("e2_co3_first", co[3], 1'b1);
    half();
    chk("e2n_co3", co[3], 1'b0);

    tick(5);  // e7
    chk("e7_lk", lk, 4'b1000);
    tick(1);  // e8
    chk("e8_lk", lk, 4'b1110);
    chk("e8_co12", co[2:1], 2'b00);
    tick(1);  // e9
    chk("e9_co12", co[2:1], 2'b10);
    half();
    chk("e9n_co2_duty", co[2], 1'b1);
    tick(1);  // e10
    chk("e10_co12", co[2:1], 2'b01);
    tick(1);  // e11
    chk("e11_co12", co[2:1], 2'b11);
    tick(1);  // e12
    chk("e12_co12", co[2:1], 2'b00);
    tick(1);  // e13
    chk("e13_co1", co[1], 1'b0);
    tick(1);  // e14
    chk("e14_co1", co[1], 1'b1);

    tick(49); // e63
    chk("e63_lk0", lk[0], 1'b0);
    tick(1);  // e64
    chk("e64_lk0", lk[0], 1'b1);
    chk("e64_co0", co[0], 1'b0);
    half();
    chk("e64n_co0", co[0], 1'b0);
    tick(1);  // e65
    chk("e65_co0", co[0], 1'b1);
    half();
    chk("e65n_co0", co[0], 1'b0);

    // Fault on e66.
    fault_req = 1'b1;
    tick(1);  // e66
    fault_req = 1'b0;
    chk("flt_lk", lk, 4'b0000);
    chk("flt_co12", co[2:1], 2'b00);
    tick(1);  // e67
    chk("flt1_co0", co[0], 1'b0);
    chk("flt1_lk", lk, 4'b1000);
    tick(6);  // e73
    chk("flt7_lk2", lk[2], 1'b0);
    tick(1);  // e74
    chk("flt8_lk12", lk[2:1], 2'b11);
    tick(1);  // e75
    chk("flt9_co2", co[2], 1'b1);
    tick(1);  // e76
    chk("flt10_co2", co[2], 1'b0);

    // One-edge reset on e77 while u1/u2/u3 are locked.
    @(negedge clk_p) rst = 1'b1;
    tick(1);  // e77
    chk("mrst_lk", lk, 4'b0000);
    chk("mrst_co", co[2:1], 2'b00);
    @(negedge clk_p) rst = 1'b0;
    tick(1);  // e78
    chk("mrst1_lk", lk, 4'b1000);
    tick(6);  // e84
    chk("mrst7_lk2", lk[2], 1'b0);
    tick(1);  // e85
    chk("mrst8_lk2", lk[2], 1'b1);
    chk("mrst8_co2", co[2], 1'b0);
    tick(1);  // e86
    chk("mrst9_co2", co[2], 1'b1);
    tick(1);  // e87
    chk("mrst10_co2", co[2], 1'b0);

    // u0 relocks 64 valid edges after the reset (e78..e141).
    tick(53); // e140
    chk("e140_lk0", lk[0], 1'b0);
    tick(1);  // e141
    chk("e141_lk0", lk[0], 1'b1);
    tick(1);  // e142
    chk("e142_co0", co[0], 1'b1);

    // Reset and fault together on e143: reset wins, counters restart from 0.
    @(negedge clk_p) begin
      rst = 1'b1;
      fault_req = 1'b1;
    end
    tick(1);  // e143
    fault_req = 1'b0;
    chk("rf_lk", lk, 4'b0000);
    chk("rf_co12", co[2:1], 2'b00);
    @(negedge clk_p) rst = 1'b0;
    #1;
    chk("rfn_co0", co[0], 1'b0);
    tick(1);  // e144
    chk("rf1_lk", lk, 4'b1000);
    chk("rf1_co0", co[0], 1'b0);
    tick(6);  // e150
    chk("rf7_lk2", lk[2], 1'b0);
    tick(1);  // e151
    chk("rf8_lk2", lk[2], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
